// File: rtl/emd_pkg.sv
// Shared types and constants for the EMD IMF extraction stage.
// IMF_SAT_EN selects saturating (defined) or wrapping (undefined) IMF subtraction.
package emd_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int DEPTH_LOG2_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

  function automatic logic [SAMPLE_W-1:0] imf_sub(input logic signed [SAMPLE_W-1:0] x,
                                                  input logic signed [SAMPLE_W-1:0] r);
`ifdef IMF_SAT_EN
    logic [SAMPLE_W:0] diff;
    diff = {x[SAMPLE_W-1], x} - {r[SAMPLE_W-1], r};
    if (diff[SAMPLE_W] != diff[SAMPLE_W-1]) begin
      return diff[SAMPLE_W] ? SAT_MIN : SAT_MAX;
    end
    return diff[SAMPLE_W-1:0];
`else
    // Low 16 bits of the 17-bit difference are the plain 16-bit wrap.
    return x - r;
`endif
  endfunction

endpackage

// File: rtl/imf_delay_ram.sv
// Alignment buffer: one write port, one registered read port, write-first on address collision.
module imf_delay_ram
  import emd_pkg::*;
#(
  parameter int AW = DEPTH_LOG2_DEF
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [SAMPLE_W-1:0] wdat_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [SAMPLE_W-1:0] rdat_o
);

  logic [SAMPLE_W-1:0] mem_q [0:(1<<AW)-1];
  logic [SAMPLE_W-1:0] rdat_q;

  // Forwarding covers LAT=1, where the sample needed next cycle is the one being written now.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdat_i;
    if (we_i && (waddr_i == raddr_i)) rdat_q <= wdat_i;
    else                              rdat_q <= mem_q[raddr_i];
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/imf_extractor.sv
// Measures residue-stage latency, delays XIN to match, and outputs IMF = XIN(delayed) - RIN one cycle after RIN.
// Build option IMF_SAT_EN: saturate IMF on 17-bit overflow instead of wrapping.
module imf_extractor
  import emd_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [15:0]           XIN,
  input  logic                  RSTART,
  input  logic [15:0]           RIN,
  output logic [15:0]           IMF,
  output logic                  IMF_VALID,
  output logic [DEPTH_LOG2-1:0] LAT,
  output logic                  OVF
);

  localparam logic [DEPTH_LOG2-1:0] CNT_MAX = '1;
  localparam logic [DEPTH_LOG2-1:0] ONE     = DEPTH_LOG2'(1);

  state_t                state_q;
  logic [DEPTH_LOG2-1:0] wptr_q, cnt_q, lat_q;
  logic [15:0]           imf_q;
  logic                  imf_vld_q, ovf_q;

  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_waddr, ram_raddr;
  logic [15:0]           ram_rdat, x_dly, imf_d;

  // Read address is issued one cycle ahead so the registered RAM output meets the RIN it pairs with.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wptr_q;
    ram_raddr = '0;
    case (state_q)
      S_IDLE: begin
        ram_we    = START;
        ram_waddr = '0;
      end
      S_FILL: begin
        ram_we = 1'b1;
        if (RSTART) ram_raddr = wptr_q + ONE - cnt_q;
      end
      S_RUN: begin
        ram_we = START;
        if (RSTART) ram_raddr = wptr_q + ONE - lat_q;
      end
      default: ;
    endcase
    x_dly = ((state_q == S_IDLE) || ((state_q == S_RUN) && (lat_q == '0))) ? XIN : ram_rdat;
    imf_d = imf_sub(x_dly, RIN);
  end

  imf_delay_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdat_i  (XIN),
    .raddr_i (ram_raddr),
    .rdat_o  (ram_rdat)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      imf_q     <= '0;
      imf_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      imf_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            wptr_q <= ONE;
            cnt_q  <= ONE;
            if (RSTART) begin
              lat_q     <= '0;
              imf_q     <= imf_d;
              imf_vld_q <= 1'b1;
              state_q   <= S_RUN;
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_FILL: begin
          wptr_q <= wptr_q + ONE;
          if (RSTART) begin
            lat_q     <= cnt_q;
            imf_q     <= imf_d;
            imf_vld_q <= 1'b1;
            state_q   <= S_RUN;
          end else if (cnt_q == CNT_MAX) begin
            ovf_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        S_RUN: begin
          // Pointer keeps advancing after START drops so the read tap still tracks in-flight samples.
          wptr_q <= wptr_q + ONE;
          if (RSTART) begin
            imf_q     <= imf_d;
            imf_vld_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign IMF       = imf_q;
  assign IMF_VALID = imf_vld_q;
  assign LAT       = lat_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_imf_extractor.sv
// Self-checking bench for imf_extractor: directed vector table plus multi-cycle stream sequences.
module tb_imf_extractor;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        RSTART = 1'b0;
  logic [15:0] XIN = 16'd0;
  logic [15:0] RIN = 16'd0;
  logic [15:0] IMF;
  logic        IMF_VALID;
  logic [7:0]  LAT;
  logic        OVF;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] hist [0:2047];

  typedef struct {
    logic        st;
    logic        rs;
    logic [15:0] x;
    logic [15:0] r;
    logic        vld;
    logic [15:0] imf;
    logic        chk;
    logic [7:0]  lat;
    logic        ovf;
  } vec_t;

  imf_extractor #(.DEPTH_LOG2(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .XIN       (XIN),
    .RSTART    (RSTART),
    .RIN       (RIN),
    .IMF       (IMF),
    .IMF_VALID (IMF_VALID),
    .LAT       (LAT),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic start_hi);
    RST_N  = 1'b0;
    START  = start_hi;
    RSTART = 1'b0;
    XIN    = 16'd0;
    RIN    = 16'd0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Called just after a falling edge; drives one cycle, then checks that cycle's result.
  task automatic run_stream(input int lat, input int n, input bit ramp, input bit do_end);
    int total;
    int xv;
    int d;
    logic [15:0] exp_imf;
    total = lat + n;
    for (int c = 0; c < total; c++) begin
      if (ramp) xv = c;
      else      xv = int'($urandom_range(32000)) - 16000;
      hist[c] = 16'(xv);
      START   = 1'b1;
      XIN     = hist[c];
      exp_imf = 16'd0;
      if (c >= lat) begin
        if (ramp) d = 5;
        else      d = int'($urandom_range(2000)) - 1000;
        RSTART  = 1'b1;
        RIN     = 16'(int'($signed(hist[c-lat])) - d);
        exp_imf = 16'(d);
      end else begin
        RSTART = 1'b0;
        RIN    = 16'd0;
      end
      @(negedge CLK);
      if (c < lat) check("fill_vld", {31'd0, IMF_VALID}, 32'd0);
      else         check("run_imf", {15'd0, IMF_VALID, IMF}, {15'd0, 1'b1, exp_imf});
      if (c == lat) check("lat_meas", {24'd0, LAT}, 32'(lat));
    end
    if (do_end) begin
      START  = 1'b0;
      RSTART = 1'b0;
      XIN    = 16'd0;
      RIN    = 16'd0;
      @(negedge CLK);
      check("end_vld", {31'd0, IMF_VALID}, 32'd0);
      check("lat_kept", {24'd0, LAT}, 32'(lat));
    end
  endtask

  initial begin
    vec_t        tbl [15];
    logic [15:0] neg_ovf_exp;
    logic [15:0] pos_ovf_exp;
    logic        saw_vld;

`ifdef IMF_SAT_EN
    neg_ovf_exp = 16'h8000;
    pos_ovf_exp = 16'h7FFF;
`else
    neg_ovf_exp = 16'h7FFF;
    pos_ovf_exp = 16'h8000;
`endif

    //          st    rs    x              r              vld   imf            chk   lat   ovf
    tbl[0]  = '{1'b0, 1'b0, 16'd0,         16'd0,         1'b0, 16'd0,         1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 16'd100,       16'd40,        1'b1, 16'd60,        1'b1, 8'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'hFFFB,      16'd7,         1'b1, 16'hFFF4,      1'b1, 8'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16'd1000,      16'hF830,      1'b1, 16'd3000,      1'b1, 8'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 16'h8000,      16'd1,         1'b1, neg_ovf_exp,   1'b1, 8'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 16'h7FFF,      16'hFFFF,      1'b1, pos_ovf_exp,   1'b1, 8'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'd0,         16'd0,         1'b0, 16'd0,         1'b0, 8'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'd0,         16'd0,         1'b0, 16'd0,         1'b0, 8'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'd10,        16'd0,         1'b0, 16'd0,         1'b0, 8'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'd20,        16'd0,         1'b0, 16'd0,         1'b0, 8'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 16'd30,        16'd7,         1'b1, 16'd3,         1'b1, 8'd2, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 16'd40,        16'd16,        1'b1, 16'd4,         1'b1, 8'd2, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 16'd0,         16'd21,        1'b1, 16'd9,         1'b1, 8'd2, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 16'd0,         16'd39,        1'b1, 16'd1,         1'b1, 8'd2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 16'd0,         16'd0,         1'b0, 16'd0,         1'b0, 8'd2, 1'b0};

    #12;
    check("reset_state", {15'd0, IMF_VALID, OVF, LAT, IMF[14:0]}, 32'd0);
    check("reset_imf_msb", {31'd0, IMF[15]}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 15; i++) begin
      START  = tbl[i].st;
      RSTART = tbl[i].rs;
      XIN    = tbl[i].x;
      RIN    = tbl[i].r;
      @(negedge CLK);
      check($sformatf("vec%0d", i),
            {6'd0, OVF, IMF_VALID, LAT, (tbl[i].chk ? IMF : 16'h0)},
            {6'd0, tbl[i].ovf, tbl[i].vld, tbl[i].lat, (tbl[i].chk ? tbl[i].imf : 16'h0)});
    end

    // Ramp with a 30-cycle residue stage: IMF constant 5, valid from the cycle after RSTART.
    do_reset(1'b0);
    run_stream(30, 70, 1'b1, 1'b1);

    // RSTART never arrives: overflow once the counter passes 255, no IMF output.
    do_reset(1'b0);
    saw_vld = 1'b0;
    START   = 1'b1;
    RSTART  = 1'b0;
    for (int c = 0; c < 260; c++) begin
      XIN = 16'(c);
      @(negedge CLK);
      if (IMF_VALID) saw_vld = 1'b1;
      if (c == 253) check("ovf_early", {31'd0, OVF}, 32'd0);
      if (c == 256) check("ovf_set", {31'd0, OVF}, 32'd1);
    end
    check("ovf_no_vld", {31'd0, saw_vld}, 32'd0);
    RSTART = 1'b1;
    for (int c = 0; c < 5; c++) @(negedge CLK);
    check("err_hold", {30'd0, OVF, IMF_VALID}, 32'd2);
    check("err_lat", {24'd0, LAT}, 32'd0);

    // Asynchronous reset in the middle of a run, then restart with START held through reset.
    do_reset(1'b0);
    run_stream(20, 40, 1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    check("midrun_rst", {15'd0, IMF_VALID, OVF, LAT, IMF[14:0]}, 32'd0);
    check("midrun_rst_msb", {31'd0, IMF[15]}, 32'd0);
    RSTART = 1'b0;
    START  = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    run_stream(7, 50, 1'b0, 1'b1);

    // Long run with several pointer wraps.
    do_reset(1'b0);
    run_stream(120, 1000, 1'b0, 1'b1);
    check("long_no_ovf", {31'd0, OVF}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imf_extractor.md
IMF_EXTRACTOR -- requirements
Module: imf_extractor

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the alignment buffer depth in samples.
REQ-002 SHALL have port CLK  input  1  meaning system clock; all logic on its rising edge.
REQ-003 SHALL have port RST_N  input  1  meaning reset, asynchronous and active-low.
REQ-004 SHALL have port START  input  1  meaning level; high from the first valid sample on XIN, same strobe as the feeding residue stage's start.
REQ-005 SHALL have port XIN  input  16  meaning signed stage-input sample (signal or previous residue).
REQ-006 SHALL have port RSTART  input  1  meaning level; residue stage's follow-on start, high once RIN is valid.
REQ-007 SHALL have port RIN  input  16  meaning signed residue produced from XIN by that stage.
REQ-008 SHALL have port IMF  output  16  meaning signed IMF sample = aligned XIN minus RIN.
REQ-009 SHALL have port IMF_VALID  output  1  meaning IMF holds a valid sample this cycle.
REQ-010 SHALL have port LAT  output  DEPTH_LOG2  meaning measured stage latency in cycles.
REQ-011 SHALL have port OVF  output  1  meaning sticky; measured latency exceeded buffer capacity.

Function
REQ-012 SHALL implement states IDLE, FILL, RUN, ERR.
REQ-013 IDLE: on START=1 SHALL write XIN at address 0, clear the latency counter to 1 and go to FILL.
REQ-014 FILL: SHALL write XIN every cycle at an incrementing wrap-around write pointer, increment the latency counter, and stay until RSTART=1.
REQ-015 FILL: on RSTART=1 SHALL latch the counter into LAT and go to RUN; START and RSTART rising in the same IDLE cycle SHALL give LAT=0 (pass-through).
REQ-016 FILL: if the counter reaches 2^DEPTH_LOG2-1 with RSTART still 0, SHALL set OVF and go to ERR.
REQ-017 RUN: SHALL read the buffer at write pointer minus LAT (modulo depth), so the sample read pairs with the RIN derived from it.
REQ-018 RUN: SHALL register IMF = delayed XIN - RIN, 17-bit internal difference, with IMF_VALID=1 exactly one cycle after the RIN sample it uses.
REQ-019 RUN: if START falls, SHALL stop writing; if RSTART falls, SHALL drop IMF_VALID the next cycle and return to IDLE with LAT retained.
REQ-020 ERR: SHALL hold IMF_VALID=0 and remain until reset.
REQ-021 Pointer wrap at 2^DEPTH_LOG2 SHALL be seamless; no bubble in IMF_VALID.

Reset
REQ-022 RST_N low SHALL immediately force state IDLE, pointers 0, IMF=0, IMF_VALID=0, LAT=0, OVF=0.
REQ-023 Reset mid-RUN SHALL discard buffered samples; buffer RAM contents need not be cleared.
REQ-024 After RST_N deassertion, START already high SHALL be treated as a new START in IDLE.

Configuration
REQ-025 With IMF_SAT_EN defined, IMF SHALL saturate to +32767 / -32768 when the 17-bit difference overflows.
REQ-026 Without IMF_SAT_EN, IMF SHALL be the low 16 bits of the difference (two's-complement wrap).

Structure
REQ-027 Package emd_pkg SHALL hold the sample width (16), the default DEPTH_LOG2, the state encoding typedef, and the saturation limit constants.
REQ-028 Buffer SHALL be a sub-module imf_delay_ram: one write port, one registered read port, DEPTH_LOG2 address bits.

Verification
REQ-029 START at t0, RSTART at t0+30, XIN ramp 0,1,2..., RIN = XIN delayed 30 minus 5 -> LAT=30, IMF=5 constant, IMF_VALID from t0+31.
REQ-030 START and RSTART together, XIN=100, RIN=40 -> LAT=0, IMF=60 next cycle.
REQ-031 RSTART never asserted, DEPTH_LOG2=8 -> OVF=1 at cycle 255, IMF_VALID stays 0.
REQ-032 XIN delayed=32767, RIN=-1 -> IMF=32767 with IMF_SAT_EN, IMF=-32768 without.
REQ-033 RST_N pulsed low mid-RUN -> IMF_VALID, LAT, OVF 0 same cycle; restart yields correct LAT.
REQ-034 LAT=120 run for 1000 cycles -> IMF correct across multiple pointer wraps, no IMF_VALID gap.
